// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm time-keeping core.
//   DIGIT_W / FIELD_W : width of one BCD digit and of one two-digit field
//   *_LSB             : field offsets inside the 48-bit display word
//   ring_state_t      : alarm-ring FSM state encoding
//   bcd_last()        : BCD encoding of the last value of a modulo-N counter
package clock_pkg;

    localparam int DIGIT_W = 4;
    localparam int FIELD_W = 2 * DIGIT_W;
    localparam int WORD_W  = 6 * FIELD_W;

    localparam int SS_LSB  = 0;
    localparam int MM_LSB  = 8;
    localparam int HH_LSB  = 16;
    localparam int ASS_LSB = 24;
    localparam int AMM_LSB = 32;
    localparam int AHH_LSB = 40;

    typedef enum logic {
        RING_IDLE   = 1'b0,
        RING_ACTIVE = 1'b1
    } ring_state_t;

    // Two-digit BCD form of (modulus - 1), e.g. 60 -> 8'h59, 24 -> 8'h23.
    function automatic logic [FIELD_W-1:0] bcd_last(input int modulus);
        int last;
        last = modulus - 1;
        return {4'(last / 10), 4'(last % 10)};
    endfunction

endpackage

// File: rtl/clock_alarm_counter_if.sv
// Control/status bundle between the button debouncer, the time-keeping core
// and the display multiplexer / buzzer driver.
//   inc_min, inc_hour : single-cycle set strobes (minute +1, hour +1)
//   alarm_d           : 0 = strobes target the time, 1 = target the alarm
//   alarm_en          : level, alarm armed
//   alarm_stop        : single-cycle strobe, silences ringing
//   counter           : {alm_hh, alm_mm, alm_ss, hh, mm, ss} packed BCD
//   sec_tick          : one-cycle pulse per second
//   alarm_ring        : high while ringing
//   ring_state        : ring FSM state, for observation
// All strobes are fire-and-forget: the core accepts them in the cycle they are
// high and there is no back-pressure path.
interface clock_alarm_counter_if;
    import clock_pkg::*;

    logic              inc_min;
    logic              inc_hour;
    logic              alarm_d;
    logic              alarm_en;
    logic              alarm_stop;
    logic [WORD_W-1:0] counter;
    logic              sec_tick;
    logic              alarm_ring;
    ring_state_t       ring_state;

    // Upstream side: debouncer / switches, reads back the display word.
    modport master (
        output inc_min, inc_hour, alarm_d, alarm_en, alarm_stop,
        input  counter, sec_tick, alarm_ring, ring_state
    );

    // Core side.
    modport slave (
        input  inc_min, inc_hour, alarm_d, alarm_en, alarm_stop,
        output counter, sec_tick, alarm_ring, ring_state
    );

endinterface

// File: rtl/clock_alarm_counter_bcd_mod_counter.sv
// Two-digit BCD modulo-N counter (N = 60 for minutes/seconds, 24 for hours).
//   clk, reset : clock, asynchronous active-high reset (loads RST_VAL)
//   inc        : advance by one, wrapping at MODULUS-1
//   clr        : synchronous clear to 00, dominates inc
//   value      : current two-digit BCD value
//   carry_out  : high when this cycle's inc wraps the counter back to 00
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int                 MODULUS = 60,
    parameter logic [FIELD_W-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [FIELD_W-1:0] value,
    output logic               carry_out
);

    localparam logic [FIELD_W-1:0] LAST = bcd_last(MODULUS);

    logic at_last;

    assign at_last   = (value == LAST);
    assign carry_out = inc & ~clr & at_last;

    // Units roll 9 -> 0 with a tens increment; the modulus check comes first so
    // 23 -> 00 wraps before the units rule would produce 24.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= RST_VAL;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            if (at_last) begin
                value <= '0;
            end else if (value[DIGIT_W-1:0] == 4'd9) begin
                value <= {value[FIELD_W-1:DIGIT_W] + 4'd1, 4'd0};
            end else begin
                value <= {value[FIELD_W-1:DIGIT_W], value[DIGIT_W-1:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/clock_alarm_counter.sv
// Time-keeping core of the digital clock: 1 Hz prescaler, BCD hh:mm:ss time,
// settable alarm hh:mm, and the alarm-ring state machine.
//   clk   : board clock (CLK_HZ cycles per second)
//   reset : asynchronous active-high reset
//   bus   : control strobes in, packed BCD word / sec_tick / alarm_ring out
// Parameters: CLK_HZ (prescaler period), RING_SEC (ring length in seconds,
// 1..255), ALARM_RST_HH (BCD alarm hour after reset).
module clock_alarm_counter
    import clock_pkg::*;
#(
    parameter int         CLK_HZ       = 50000000,
    parameter int         RING_SEC     = 30,
    parameter logic [7:0] ALARM_RST_HH = 8'h07
) (
    input  logic                  clk,
    input  logic                  reset,
    clock_alarm_counter_if.slave  bus
);

    localparam int                 PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CLK_HZ - 1);
    localparam logic [7:0]         RING_LAST = 8'(RING_SEC);
    localparam logic [FIELD_W-1:0] ALARM_SS  = '0;

    logic [PRE_W-1:0]   prescaler;
    logic               tick;
    logic               set_t_min;
    logic               set_t_hour;
    logic               set_a_min;
    logic               set_a_hour;
    logic               tick_time;
    logic               tick_applied;

    logic [FIELD_W-1:0] ss_val;
    logic [FIELD_W-1:0] mm_val;
    logic [FIELD_W-1:0] hh_val;
    logic [FIELD_W-1:0] amm_val;
    logic [FIELD_W-1:0] ahh_val;
    logic               ss_carry;
    logic               mm_carry;
    logic               mm_tick_carry;
    logic               hh_carry_unused;
    logic               amm_carry_unused;
    logic               ahh_carry_unused;

    logic               time_match;
    ring_state_t        state;
    logic [7:0]         ring_cnt;
    logic               alarm_ring_r;
    logic [WORD_W-1:0]  word;

    // ------------------------------------------------------------------
    // Prescaler and set-strobe decode
    // ------------------------------------------------------------------
    assign tick       = (prescaler == PRE_LAST);
    assign set_t_min  = bus.inc_min  & ~bus.alarm_d;
    assign set_t_hour = bus.inc_hour & ~bus.alarm_d;
    assign set_a_min  = bus.inc_min  &  bus.alarm_d;
    assign set_a_hour = bus.inc_hour &  bus.alarm_d;

    // A time minute-set discards a coincident tick entirely.
    assign tick_time  = tick & ~set_t_min;

    // Minute-set restarts the second so the new minute begins at :00 exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (set_t_min || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Time of day
    // ------------------------------------------------------------------
    bcd_mod_counter #(.MODULUS(60), .RST_VAL(8'h00)) u_ss (
        .clk       (clk),
        .reset     (reset),
        .inc       (tick_time),
        .clr       (set_t_min),
        .value     (ss_val),
        .carry_out (ss_carry)
    );

    bcd_mod_counter #(.MODULUS(60), .RST_VAL(8'h00)) u_mm (
        .clk       (clk),
        .reset     (reset),
        .inc       (set_t_min | ss_carry),
        .clr       (1'b0),
        .value     (mm_val),
        .carry_out (mm_carry)
    );

    // Only a wrap caused by the seconds chain reaches the hours; a minute-set
    // wrap 59 -> 00 leaves the hour alone. ss_carry can only be high when no
    // minute-set is present, so gating with it isolates the tick path.
    assign mm_tick_carry = mm_carry & ss_carry;

    // An hour-set and a tick carry in the same cycle advance the hour once.
    bcd_mod_counter #(.MODULUS(24), .RST_VAL(8'h00)) u_hh (
        .clk       (clk),
        .reset     (reset),
        .inc       (set_t_hour | mm_tick_carry),
        .clr       (1'b0),
        .value     (hh_val),
        .carry_out (hh_carry_unused)
    );

    // ------------------------------------------------------------------
    // Alarm setting (seconds fixed at 00)
    // ------------------------------------------------------------------
    bcd_mod_counter #(.MODULUS(60), .RST_VAL(8'h00)) u_alm_mm (
        .clk       (clk),
        .reset     (reset),
        .inc       (set_a_min),
        .clr       (1'b0),
        .value     (amm_val),
        .carry_out (amm_carry_unused)
    );

    bcd_mod_counter #(.MODULUS(24), .RST_VAL(ALARM_RST_HH)) u_alm_hh (
        .clk       (clk),
        .reset     (reset),
        .inc       (set_a_hour),
        .clr       (1'b0),
        .value     (ahh_val),
        .carry_out (ahh_carry_unused)
    );

    // ------------------------------------------------------------------
    // Alarm ring FSM
    // ------------------------------------------------------------------
    // Marks the cycle right after a tick updated the time; set strobes never
    // raise it, so setting the time onto the alarm cannot start a ring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_applied <= 1'b0;
        end else begin
            tick_applied <= tick_time;
        end
    end

    assign time_match = (hh_val == ahh_val) && (mm_val == amm_val) && (ss_val == ALARM_SS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RING_IDLE;
            ring_cnt     <= '0;
            alarm_ring_r <= 1'b0;
        end else begin
            case (state)
                RING_IDLE: begin
                    // alarm_stop in the same cycle suppresses entry.
                    if (tick_applied && time_match && bus.alarm_en && !bus.alarm_stop) begin
                        state        <= RING_ACTIVE;
                        ring_cnt     <= '0;
                        alarm_ring_r <= 1'b1;
                    end
                end
                RING_ACTIVE: begin
                    if (bus.alarm_stop || !bus.alarm_en || ring_cnt == RING_LAST) begin
                        state        <= RING_IDLE;
                        alarm_ring_r <= 1'b0;
                    end else if (tick) begin
                        ring_cnt <= ring_cnt + 8'd1;
                    end
                end
                default: begin
                    state        <= RING_IDLE;
                    alarm_ring_r <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        word = '0;
        word[SS_LSB  +: FIELD_W] = ss_val;
        word[MM_LSB  +: FIELD_W] = mm_val;
        word[HH_LSB  +: FIELD_W] = hh_val;
        word[ASS_LSB +: FIELD_W] = ALARM_SS;
        word[AMM_LSB +: FIELD_W] = amm_val;
        word[AHH_LSB +: FIELD_W] = ahh_val;
    end

    assign bus.counter    = word;
    assign bus.sec_tick   = tick;
    assign bus.alarm_ring = alarm_ring_r;
    assign bus.ring_state = state;

endmodule

// File: tb/tb_clock_alarm_counter.sv
// Self-checking bench for clock_alarm_counter with CLK_HZ=4, RING_SEC=3.
module tb_clock_alarm_counter;
    import clock_pkg::*;

    localparam int CLK_HZ   = 4;
    localparam int RING_SEC = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    clock_alarm_counter_if bus ();

    clock_alarm_counter #(
        .CLK_HZ       (CLK_HZ),
        .RING_SEC     (RING_SEC),
        .ALARM_RST_HH (8'h07)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard / model state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q[$];
    logic [47:0] exp_w;

    int m_pre, m_hh, m_mm, m_ss, m_ahh, m_amm;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [47:0] model_word();
        return {to_bcd(m_ahh), to_bcd(m_amm), 8'h00, to_bcd(m_hh), to_bcd(m_mm), to_bcd(m_ss)};
    endfunction

    task automatic model_reset();
        m_pre = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_ahh = 7; m_amm = 0;
    endtask

    // Advance one clock; the model applies the currently driven inputs first.
    task automatic step();
        bit tick, t_min, t_hour, hour_carry;
        tick       = (m_pre == CLK_HZ - 1);
        t_min      = bus.inc_min  && !bus.alarm_d;
        t_hour     = bus.inc_hour && !bus.alarm_d;
        hour_carry = 0;
        if (bus.alarm_d) begin
            if (bus.inc_min)  m_amm = (m_amm + 1) % 60;
            if (bus.inc_hour) m_ahh = (m_ahh + 1) % 24;
        end
        if (t_min) begin
            m_mm = (m_mm + 1) % 60;
            m_ss = 0;
        end else if (tick) begin
            m_ss = m_ss + 1;
            if (m_ss == 60) begin
                m_ss = 0;
                m_mm = m_mm + 1;
                if (m_mm == 60) begin
                    m_mm = 0;
                    hour_carry = 1;
                end
            end
        end
        if (t_hour || hour_carry) m_hh = (m_hh + 1) % 24;
        m_pre = (t_min || tick) ? 0 : m_pre + 1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_time(input int hh, input int mm);
        int h_n, m_n;
        h_n = (hh - m_hh + 24) % 24;
        m_n = (mm - m_mm + 60) % 60;
        while (m_n == 0 || m_n < h_n) m_n += 60;
        bus.alarm_d = 1'b0;
        for (int i = 0; i < m_n; i++) begin
            bus.inc_min  = 1'b1;
            bus.inc_hour = (i < h_n);
            step();
            bus.inc_min  = 1'b0;
            bus.inc_hour = 1'b0;
            step();
        end
    endtask

    task automatic set_alarm(input int hh, input int mm);
        int h_n, m_n;
        h_n = (hh - m_ahh + 24) % 24;
        m_n = (mm - m_amm + 60) % 60;
        bus.alarm_d = 1'b1;
        for (int i = 0; i < h_n; i++) begin
            bus.inc_hour = 1'b1; step(); bus.inc_hour = 1'b0; step();
        end
        for (int i = 0; i < m_n; i++) begin
            bus.inc_min = 1'b1; step(); bus.inc_min = 1'b0; step();
        end
        bus.alarm_d = 1'b0;
    endtask

    // Step to the next tick cycle, confirm sec_tick, then apply it.
    task automatic next_tick(input string name);
        for (int n = 0; n < 2 * CLK_HZ && m_pre != CLK_HZ - 1; n++) step();
        checks++;
        if (bus.sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL %s sec_tick: got %b expected 1", name, bus.sec_tick);
        end
        step();
    endtask

    // Step until the tick cycle in which the displayed time is hh:mm:ss.
    task automatic wait_tick_at(input string name, input int hh, input int mm, input int ss);
        int n;
        for (n = 0; n < 400 && !(m_hh == hh && m_mm == mm && m_ss == ss && m_pre == CLK_HZ - 1); n++)
            step();
        if (n == 400) begin
            errors++;
            $display("FAIL %s timeout waiting for %0d:%0d:%0d", name, hh, mm, ss);
        end
        checks++;
        if (bus.sec_tick !== 1'b1 || bus.counter !== model_word()) begin
            errors++;
            $display("FAIL %s at tick: got tick=%b counter=%h expected tick=1 counter=%h",
                     name, bus.sec_tick, bus.counter, model_word());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.inc_min = 0; bus.inc_hour = 0; bus.alarm_d = 0; bus.alarm_en = 0; bus.alarm_stop = 0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.counter !== 48'h07_00_00_00_00_00 || bus.alarm_ring !== 1'b0 || bus.sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got counter=%h ring=%b tick=%b expected 070000000000/0/0",
                     bus.counter, bus.alarm_ring, bus.sec_tick);
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (bus.sec_tick !== (k == 3)) begin
                errors++;
                $display("FAIL first_tick cycle %0d: got %b expected %b", k + 1, bus.sec_tick, (k == 3));
            end
        end
        exp_q.push_back(48'h07_00_00_00_00_01);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL first_second: got %h expected %h", bus.counter, exp_w);
        end
        // async reset mid-count
        bus.inc_min = 1'b1; step(); bus.inc_min = 1'b0;
        step(); step();
        exp_q.push_back(model_word());
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL before_async_reset: got %h expected %h", bus.counter, exp_w);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.counter !== 48'h07_00_00_00_00_00 || bus.alarm_ring !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got counter=%h ring=%b expected 070000000000/0",
                     bus.counter, bus.alarm_ring);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_rollover();
        set_time(23, 59);
        wait_tick_at("rollover_58", 23, 59, 58);
        exp_q.push_back(48'h07_00_00_23_59_59);
        step();
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL rollover_59: got %h expected %h", bus.counter, exp_w);
        end
        exp_q.push_back(48'h07_00_00_00_00_00);
        next_tick("rollover_wrap");
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL rollover_wrap: got %h expected %h", bus.counter, exp_w);
        end
    endtask

    task automatic test_set_isolation();
        set_time(10, 59);
        repeat (3) next_tick("iso_run");
        exp_q.push_back(48'h07_00_00_10_00_00);
        bus.inc_min = 1'b1; step(); bus.inc_min = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL min_no_carry: got %h expected %h", bus.counter, exp_w);
        end
        set_time(23, 0);
        next_tick("iso_hh_a");
        next_tick("iso_hh_b");
        exp_q.push_back(48'h07_00_00_00_00_02);
        bus.inc_hour = 1'b1; step(); bus.inc_hour = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL hour_wrap_set: got %h expected %h", bus.counter, exp_w);
        end
        exp_q.push_back(48'h08_00_00_00_00_02);
        bus.alarm_d = 1'b1;
        bus.inc_hour = 1'b1; step(); bus.inc_hour = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL alarm_hour_set: got %h expected %h", bus.counter, exp_w);
        end
        exp_q.push_back(48'h08_01_00_00_00_02);
        bus.inc_min = 1'b1; step(); bus.inc_min = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL alarm_min_set: got %h expected %h", bus.counter, exp_w);
        end
        exp_q.push_back(48'h08_01_00_00_00_03);
        next_tick("alarm_d_runs");
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL time_runs_alarm_d: got %h expected %h", bus.counter, exp_w);
        end
        bus.alarm_d = 1'b0;
    endtask

    task automatic test_collision();
        set_time(5, 10);
        wait_tick_at("collide_wait", 5, 10, 30);
        exp_q.push_back(48'h08_01_00_05_11_00);
        bus.inc_min = 1'b1; step(); bus.inc_min = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL tick_set_collision: got %h expected %h", bus.counter, exp_w);
        end
        exp_q.push_back(48'h08_01_00_05_11_01);
        next_tick("collide_restart");
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL collision_restart: got %h expected %h", bus.counter, exp_w);
        end
    endtask

    task automatic test_alarm_ring();
        set_alarm(7, 1);
        set_time(7, 0);
        bus.alarm_en = 1'b1;
        wait_tick_at("ring_wait", 7, 0, 59);
        exp_q.push_back(48'h07_01_00_07_01_00);
        step();
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w || bus.alarm_ring !== 1'b0) begin
            errors++;
            $display("FAIL ring_t1: got counter=%h ring=%b expected %h/0", bus.counter, bus.alarm_ring, exp_w);
        end
        step();
        checks++;
        if (bus.alarm_ring !== 1'b1 || bus.ring_state !== RING_ACTIVE) begin
            errors++;
            $display("FAIL ring_t2: got ring=%b state=%0d expected 1/1", bus.alarm_ring, bus.ring_state);
        end
        next_tick("ring_tick1");
        next_tick("ring_tick2");
        checks++;
        if (bus.alarm_ring !== 1'b1) begin
            errors++;
            $display("FAIL ring_hold: got %b expected 1", bus.alarm_ring);
        end
        next_tick("ring_tick3");
        exp_q.push_back(48'h07_01_00_07_01_03);
        step();
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.alarm_ring !== 1'b0 || bus.counter !== exp_w) begin
            errors++;
            $display("FAIL ring_timeout: got ring=%b counter=%h expected 0/%h", bus.alarm_ring, bus.counter, exp_w);
        end
        // again, silenced by alarm_stop after one tick
        set_time(7, 0);
        wait_tick_at("stop_wait", 7, 0, 59);
        step();
        step();
        checks++;
        if (bus.alarm_ring !== 1'b1) begin
            errors++;
            $display("FAIL stop_ring_on: got %b expected 1", bus.alarm_ring);
        end
        next_tick("stop_tick1");
        bus.alarm_stop = 1'b1; step(); bus.alarm_stop = 1'b0;
        checks++;
        if (bus.alarm_ring !== 1'b0) begin
            errors++;
            $display("FAIL stop_drop: got %b expected 0", bus.alarm_ring);
        end
        step();
        checks++;
        if (bus.alarm_ring !== 1'b0 || bus.ring_state !== RING_IDLE) begin
            errors++;
            $display("FAIL stop_stays_idle: got ring=%b state=%0d expected 0/0", bus.alarm_ring, bus.ring_state);
        end
    endtask

    task automatic test_no_false_trigger();
        bus.alarm_en = 1'b0;
        set_time(7, 0);
        wait_tick_at("disabled_wait", 7, 0, 59);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.alarm_ring !== 1'b0) begin
                errors++;
                $display("FAIL disabled_no_ring cycle %0d: got %b expected 0", k, bus.alarm_ring);
            end
        end
        // stop in the evaluation cycle blocks entry
        bus.alarm_en = 1'b1;
        set_time(7, 0);
        wait_tick_at("stop_prio_wait", 7, 0, 59);
        step();
        bus.alarm_stop = 1'b1; step(); bus.alarm_stop = 1'b0;
        step();
        checks++;
        if (bus.alarm_ring !== 1'b0) begin
            errors++;
            $display("FAIL stop_priority: got %b expected 0", bus.alarm_ring);
        end
        // setting the time onto the alarm never rings
        set_time(7, 0);
        exp_q.push_back(48'h07_01_00_07_01_00);
        bus.inc_min = 1'b1; step(); bus.inc_min = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.counter !== exp_w) begin
            errors++;
            $display("FAIL set_to_match: got %h expected %h", bus.counter, exp_w);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.alarm_ring !== 1'b0) begin
                errors++;
                $display("FAIL set_no_ring cycle %0d: got %b expected 0", k, bus.alarm_ring);
            end
        end
    endtask

    task automatic test_reset_mid_ring();
        set_time(7, 0);
        wait_tick_at("mid_ring_wait", 7, 0, 59);
        step();
        step();
        checks++;
        if (bus.alarm_ring !== 1'b1) begin
            errors++;
            $display("FAIL mid_ring_on: got %b expected 1", bus.alarm_ring);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.alarm_ring !== 1'b0 || bus.counter !== 48'h07_00_00_00_00_00) begin
            errors++;
            $display("FAIL mid_ring_reset: got ring=%b counter=%h expected 0/070000000000",
                     bus.alarm_ring, bus.counter);
        end
        model_reset();
        bus.alarm_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        checks++;
        if (bus.ring_state !== RING_IDLE || bus.alarm_ring !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got state=%0d ring=%b expected 0/0", bus.ring_state, bus.alarm_ring);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_rollover();
        test_set_isolation();
        test_collision();
        test_alarm_ring();
        test_no_false_trigger();
        test_reset_mid_ring();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
